// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// States, port ids and the data word width.
package dmem_arb_pkg;

  localparam int WORD_W = 32;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-input arbiter: round-robin on a pointer or fixed port-0 priority.
// The port just served is masked so a still-high req is ignored in DONE.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] live;
  logic       pref;

  assign live      = req & ~mask;
  assign pref      = ROUND_ROBIN ? ptr : PORT_CPU;
  assign gnt_valid = |live;
  assign gnt_idx   = live[pref] ? pref : ~pref;

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage and loader.
// One latched command drives the memory for one cycle, then acks.
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_LOG2  = 7,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_write,
  input  logic [WORD_W-1:0] p0_address,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_write,
  input  logic [WORD_W-1:0] p1_address,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_data_write,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_read_data
);

  state_t            state;
  logic              ptr;
  logic              cmd_port;
  logic              cmd_write;
  logic              cmd_err;
  logic [WORD_W-1:0] cmd_address;
  logic [WORD_W-1:0] cmd_wdata;

  logic [1:0]        req_vec;
  logic [1:0]        mask;
  logic              gnt_valid;
  logic              gnt_idx;

  logic              sel_write;
  logic              sel_err;
  logic [WORD_W-1:0] sel_address;
  logic [WORD_W-1:0] sel_wdata;

  assign req_vec = {p1_req, p0_req};
  assign mask    = (state == DONE)
                 ? (cmd_port ? 2'b10 : 2'b01)
                 : 2'b00;

  rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN != 0)
  ) u_arb (
    .req       (req_vec),
    .ptr       (ptr),
    .mask      (mask),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Route the winning port's command toward the latch
  always_comb begin
    sel_write   = p0_write;
    sel_address = p0_address;
    sel_wdata   = p0_wdata;
    if (gnt_idx == PORT_LOAD) begin
      sel_write   = p1_write;
      sel_address = p1_address;
      sel_wdata   = p1_wdata;
    end
  end

  assign sel_err = |sel_address[WORD_W-1:DEPTH_LOG2];

  assign mem_address    = cmd_address;
  assign mem_data_write = cmd_wdata;
  assign mem_write      = (state == ACCESS) & cmd_write & ~cmd_err;
  assign mem_read       = (state == ACCESS) & ~cmd_write & ~cmd_err;

  // Sequencer: latch, access for one cycle, then ack the served port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= PORT_CPU;
      cmd_port    <= PORT_CPU;
      cmd_write   <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_address <= '0;
      cmd_wdata   <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_err      <= 1'b0;
      p1_err      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (gnt_valid) begin
            cmd_port    <= gnt_idx;
            cmd_write   <= sel_write;
            cmd_err     <= sel_err;
            cmd_address <= sel_address;
            cmd_wdata   <= sel_wdata;
            ptr         <= ~gnt_idx;
            state       <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= DONE;
          if (cmd_port == PORT_LOAD) begin
            p1_ack <= 1'b1;
            p1_err <= cmd_err;
            if (mem_read) p1_rdata <= mem_read_data;
          end else begin
            p0_ack <= 1'b1;
            p0_err <= cmd_err;
            if (mem_read) p0_rdata <= mem_read_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter.
// Requester tasks push expectations; a monitor checks every ack.
module tb_data_memory_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  wr = 2'b00;
  logic [31:0] ad0 = '0, ad1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;

  logic        ack0, ack1, err0, err1;
  logic [31:0] rd0, rd1;
  logic [31:0] mem_address, mem_data_write, mem_read_data;
  logic        mem_write, mem_read;

  logic [31:0] ram [128] = '{default: '0};

  logic [1:0]  f_req = 2'b00;
  logic        f_ack0, f_ack1, f_err0, f_err1;
  logic [31:0] f_rd0, f_rd1, f_maddr, f_mdw, f_mrd;
  logic        f_mw, f_mr;

  logic [31:0] ref_mem [128];
  logic [31:0] last_rd [2];
  exp_t        q0[$];
  exp_t        q1[$];

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  always #5 clock = ~clock;

  // Cycle counter used to measure ack latency
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural data memory
  always @(posedge clock) if (mem_write) ram[mem_address[6:0]] <= mem_data_write;
  assign mem_read_data = ram[mem_address[6:0]];

  assign f_mrd = f_maddr + 32'h1000;

  data_memory_arbiter #(.DEPTH_LOG2(7), .ROUND_ROBIN(1)) dut (
    .clock(clock), .reset(reset),
    .p0_req(req[0]), .p0_write(wr[0]), .p0_address(ad0),
    .p0_wdata(wd0), .p0_ack(ack0), .p0_rdata(rd0), .p0_err(err0),
    .p1_req(req[1]), .p1_write(wr[1]), .p1_address(ad1),
    .p1_wdata(wd1), .p1_ack(ack1), .p1_rdata(rd1), .p1_err(err1),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_write(mem_data_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  data_memory_arbiter #(.DEPTH_LOG2(7), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .p0_req(f_req[0]), .p0_write(1'b0), .p0_address(32'd3),
    .p0_wdata(32'd0), .p0_ack(f_ack0), .p0_rdata(f_rd0), .p0_err(f_err0),
    .p1_req(f_req[1]), .p1_write(1'b0), .p1_address(32'd4),
    .p1_wdata(32'd0), .p1_ack(f_ack1), .p1_rdata(f_rd1), .p1_err(f_err1),
    .mem_address(f_maddr), .mem_write(f_mw),
    .mem_data_write(f_mdw), .mem_read(f_mr),
    .mem_read_data(f_mrd)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    nchk++;
    nfail++;
    $display("FAIL %s", nm);
  endtask

  // One access on port p; starts and ends 1 time unit after a rising edge
  task automatic acc(input int p, input bit w, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output bit mw);
    exp_t e;
    int k;
    logic [6:0] idx;
    idx = a[6:0];
    e.err = (a[31:7] != 0);
    if (!e.err && w) ref_mem[idx] = d;
    if (!e.err && !w) last_rd[p] = ref_mem[idx];
    e.rdata = last_rd[p];
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
    k = cyc;
    mw = 1'b0;
    lat = -1;
    wr[p] = w;
    if (p == 0) begin ad0 = a; wd0 = d; end
    else begin ad1 = a; wd1 = d; end
    req[p] = 1'b1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clock);
      if (mem_write) mw = 1'b1;
      if ((p == 0) ? ack0 : ack1) lat = cyc - k;
    end
    @(posedge clock);
    #1;
    req[p] = 1'b0;
    if (lat < 0) fail_now($sformatf("ack_timeout_p%0d", p));
  endtask

  task automatic rnd_port(input int p, input int n);
    int lat;
    bit mw;
    bit w;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
      a = 32'(p * 64) + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0)
        a = a | (32'($urandom_range(1, 1000)) << 7);
      w = ($urandom_range(0, 1) == 1);
      acc(p, w, a, $urandom, lat, mw);
    end
  endtask

  task automatic fp_pair(input logic [1:0] reqs, output int c0, output int c1);
    int k;
    c0 = -1;
    c1 = -1;
    k = cyc;
    f_req = reqs;
    for (int i = 0; i < 20 && f_req != 2'b00; i++) begin
      @(negedge clock);
      if (f_ack0) c0 = cyc - k;
      if (f_ack1) c1 = cyc - k;
      @(posedge clock);
      #1;
      if (c0 >= 0) f_req[0] = 1'b0;
      if (c1 >= 0) f_req[1] = 1'b0;
    end
    f_req = 2'b00;
  endtask

  // Monitor: every ack is matched against the oldest expectation
  always @(negedge clock) begin
    exp_t e;
    if (ack0 || ack1) chk("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
    if (ack0) begin
      if (q0.size() == 0) fail_now("p0_unexpected_ack");
      else begin
        e = q0.pop_front();
        chk("p0_err", {31'b0, err0}, {31'b0, e.err});
        chk("p0_rdata", rd0, e.rdata);
      end
    end
    if (ack1) begin
      if (q1.size() == 0) fail_now("p1_unexpected_ack");
      else begin
        e = q1.pop_front();
        chk("p1_err", {31'b0, err1}, {31'b0, e.err});
        chk("p1_rdata", rd1, e.rdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, s0, s1, kf, c0, c1;
    bit m0, m1;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ack_err", {28'b0, ack1, ack0, err1, err0}, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_data_write, 32'd0);
    chk("rst_mem_rw", {30'b0, mem_write, mem_read}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("idle_mem_rw", {30'b0, mem_write, mem_read}, 32'd0);
    end
    @(posedge clock);
    #1;

    fork
      acc(0, 1'b0, 32'd10, 32'd0, l0, m0);
      acc(1, 1'b0, 32'd70, 32'd0, l1, m1);
    join
    chk("sim_rr_p0_lat", l0, 32'd2);
    chk("sim_rr_p1_lat", l1, 32'd4);

    acc(0, 1'b1, 32'd5, 32'hDEADBEEF, l0, m0);
    chk("wr5_lat", l0, 32'd2);
    chk("wr5_memwrite", {31'b0, m0}, 32'd1);
    acc(0, 1'b0, 32'd5, 32'd0, l0, m0);
    chk("rd5_lat", l0, 32'd2);

    fork
      acc(0, 1'b1, 32'd20, $urandom, l0, m0);
      acc(1, 1'b1, 32'd90, $urandom, l1, m1);
    join
    chk("sim_rr2_p1_lat", l1, 32'd2);
    chk("sim_rr2_p0_lat", l0, 32'd4);

    acc(0, 1'b1, 32'd0, 32'hCAFE0000, l0, m0);
    acc(1, 1'b1, 32'h80, 32'h55555555, l1, m1);
    chk("oor_lat", l1, 32'd2);
    chk("oor_no_memwrite", {31'b0, m1}, 32'd0);
    acc(1, 1'b0, 32'd0, 32'd0, l1, m1);

    kf = cyc;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          s0 = cyc;
          acc(0, i[0], 32'(i * 2), $urandom, l0, m0);
          chk($sformatf("fair_p0_%0d", i), s0 + l0, kf + 2 + 4 * i);
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          s1 = cyc;
          acc(1, ~j[0], 32'(64 + j), $urandom, l1, m1);
          chk($sformatf("fair_p1_%0d", j), s1 + l1, kf + 4 + 4 * j);
        end
      end
    join

    fork
      rnd_port(0, 25);
      rnd_port(1, 25);
    join

    fp_pair(2'b01, c0, c1);
    chk("fp_single_p0", c0, 32'd2);
    chk("fp_single_p1", c1, 32'hFFFFFFFF);
    for (int r = 0; r < 2; r++) begin
      fp_pair(2'b11, c0, c1);
      chk($sformatf("fp_both_p0_%0d", r), c0, 32'd2);
      chk($sformatf("fp_both_p1_%0d", r), c1, 32'd4);
    end
    chk("fp_rd0", f_rd0, 32'h1003);
    chk("fp_rd1", f_rd1, 32'h1004);

    acc(0, 1'b1, 32'd9, 32'h11111111, l0, m0);
    wr[0] = 1'b1;
    ad0 = 32'd9;
    wd0 = 32'h22222222;
    req[0] = 1'b1;
    @(posedge clock);
    #2;
    chk("mid_memwrite_on", {31'b0, mem_write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_memwrite_drop", {31'b0, mem_write}, 32'd0);
    @(posedge clock);
    #1;
    req[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clock);
    chk("mid_ram9", ram[9], 32'h11111111);
    chk("mid_rd0", rd0, 32'd0);
    @(posedge clock);
    #1;
    fork
      acc(0, 1'b0, 32'd9, 32'd0, l0, m0);
      acc(1, 1'b0, 32'd100, 32'd0, l1, m1);
    join
    chk("post_rst_p0_lat", l0, 32'd2);
    chk("post_rst_p1_lat", l1, 32'd4);

    repeat (4) @(posedge clock);
    chk("sb_empty", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
